data_unit: RTL and testbench
============================

Name: data_unit

Overview:
- YASAC datapath: the receiving end of the control-unit interface.
- Holds the program counter (PC), the instruction register (IR), an 8x8-bit register file, the ALU and the zero/carry flags.
- Executes the control strobes (op, ipc, clpc, wir, wreg, inm) each cycle and returns the current opcode to the control unit.
- Fetches instructions from an external, combinationally read program memory.

Parameters:
- PC_W, 8, width of PC and program-memory address; PC wraps modulo 2^PC_W.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- op  in  2  ALU operation code (shared header: ALU_TRB, ALU_ADD, ALU_SUB, fourth code reserved)
- ipc  in  1  PC increment
- clpc  in  1  PC clear
- wir  in  1  load IR from mem_data
- wreg  in  1  write ALU result to R[rd]; update flags
- inm  in  1  ALU operand B = immediate instead of R[rb]
- mem_addr  out  PC_W  program-memory address, equal to PC
- mem_data  in  16  instruction word at mem_addr, same cycle
- opcode  out  5  IR[15:11], to control unit
- zero  out  1  zero flag
- carry  out  1  carry/borrow flag
- dbg_sel  in  3  register-file debug read select
- dbg_data  out  8  R[dbg_sel], combinational, for testbench

Behaviour:
- Reset is clk / reset, synchronous, active-high. On reset: PC=0, IR=16'h0000 (opcode=STOP), all 8 registers=0, zero=0, carry=0. Reset wins over all strobes, including mid-instruction.
- Instruction fields:
  - opcode = IR[15:11]
  - rd = IR[10:8]
  - ra = IR[7:5]
  - rb = IR[4:2]
  - imm = IR[7:0]
  - IR[1:0] are unused.
- PC:
  - clpc -> PC=0 next edge; clpc has priority over ipc.
  - ipc -> PC+1 next edge; PC=2^PC_W-1 wraps to 0.
  - Neither asserted -> PC holds.
- IR: wir -> IR=mem_data at the edge; otherwise IR holds.
- ALU (combinational):
  - Operand A = R[ra].
  - Operand B = imm if inm, else R[rb].
  - Result is a 9-bit intermediate, res.
  - ALU_TRB: res = {1'b0, B}.
  - ALU_ADD: res = A + B; res[8] = carry out.
  - ALU_SUB: res = A - B in 9 bits; res[8] = 1 on borrow (A < B unsigned).
  - Reserved code: res = 0.
- Write-back: wreg -> R[rd] = res[7:0], zero = (res[7:0]==0), carry = res[8]. Without wreg, registers and flags hold.
- Read-before-write: ra, rb or rd may alias; operands read old register values, and the new value is visible the next cycle.
- wir and wreg asserted in the same cycle: both take effect. Write-back decodes rd/ra/rb/imm from the old IR; IR updates at the same edge.
- Latency: the FETCH cycle (wir+ipc) loads IR and advances PC; the EXEC cycle (wreg) commits the result. Opcode is valid from the cycle after wir.
- mem_addr = PC with no register stage. mem_data is sampled only when wir=1.
- All outputs are glitch-free functions of registers, except dbg_data (mux of the register file by dbg_sel).

Decomposition:
- globals.vh (shared) holds:
  - opcode constants STOP, LDI, ADD, SUB, MOV (STOP = 5'b00000);
  - ALU constants ALU_TRB, ALU_ADD, ALU_SUB;
  - instruction field positions.
- Sub-module reg_file: 8x8 bits, two async read ports plus the debug port, one sync write port, synchronous clear.
- ALU stays inline in data_unit.

Test Plan:
- Reset, then clpc=1 with PC=5 -> PC=0, opcode=0, dbg_data=0 for all dbg_sel 0..7, zero=carry=0.
- mem_data = LDI r3,#0x7F, wir=ipc=1, then op=ALU_TRB, inm=wreg=1 -> PC+1, R3=0x7F, zero=0, carry=0.
- R1=0xF0, R2=0x20, IR = ADD r4,r1,r2, op=ALU_ADD, wreg=1 -> R4=0x10, carry=1, zero=0. Then SUB r5,r2,r2 -> R5=0x00, zero=1, carry=0.
- R1=0x05, R2=0x07, SUB r1,r1,r2 -> R1=0xFE, carry=1 (borrow). MOV r6,r1 (ALU_TRB, inm=0) -> R6=0xFE, carry=0.
- PC=2^PC_W-1 with ipc=1 -> PC=0. clpc=ipc=1 together -> PC=0.
- Mid-EXEC reset with wreg=1 targeting R3 -> R3=0, IR=0, PC=0; wreg=1 with no wir -> IR and PC unchanged.

Source files
------------

// File: rtl/data_unit_pkg.sv
// rtl/data_unit_pkg.sv - shared YASAC opcodes, ALU codes and instruction field helpers
package data_unit_pkg;

    typedef enum logic [4:0] {
        OPC_STOP = 5'b00000,
        OPC_LDI  = 5'b00001,
        OPC_ADD  = 5'b00010,
        OPC_SUB  = 5'b00011,
        OPC_MOV  = 5'b00100
    } opcode_t;

    typedef enum logic [1:0] {
        ALU_TRB = 2'b00,
        ALU_ADD = 2'b01,
        ALU_SUB = 2'b10,
        ALU_RSV = 2'b11
    } alu_op_t;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 11;
    localparam int RD_MSB  = 10;
    localparam int RD_LSB  = 8;
    localparam int RA_MSB  = 7;
    localparam int RA_LSB  = 5;
    localparam int RB_MSB  = 4;
    localparam int RB_LSB  = 2;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    function automatic logic [4:0] f_opcode(input logic [15:0] w);
        return w[OPC_MSB:OPC_LSB];
    endfunction

    function automatic logic [2:0] f_rd(input logic [15:0] w);
        return w[RD_MSB:RD_LSB];
    endfunction

    function automatic logic [2:0] f_ra(input logic [15:0] w);
        return w[RA_MSB:RA_LSB];
    endfunction

    function automatic logic [2:0] f_rb(input logic [15:0] w);
        return w[RB_MSB:RB_LSB];
    endfunction

    function automatic logic [7:0] f_imm(input logic [15:0] w);
        return w[IMM_MSB:IMM_LSB];
    endfunction

endpackage

// File: rtl/data_unit_reg_file.sv
// rtl/data_unit_reg_file.sv - 8x8 register file, two async reads, debug read, one sync write
module data_unit_reg_file
    import data_unit_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       we,
    input  logic [2:0] waddr,
    input  logic [7:0] wdata,
    input  logic [2:0] raddr_a,
    output logic [7:0] rdata_a,
    input  logic [2:0] raddr_b,
    output logic [7:0] rdata_b,
    input  logic [2:0] dbg_sel,
    output logic [7:0] dbg_data
);

    logic [7:0] regs [8];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= 8'h00;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    // Reads see the pre-edge contents, so aliased rd/ra/rb use old values.
    assign rdata_a  = regs[raddr_a];
    assign rdata_b  = regs[raddr_b];
    assign dbg_data = regs[dbg_sel];

endmodule

// File: rtl/data_unit.sv
// rtl/data_unit.sv - YASAC datapath: PC, IR, register file, ALU and flags
module data_unit
    import data_unit_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      op,
    input  logic            ipc,
    input  logic            clpc,
    input  logic            wir,
    input  logic            wreg,
    input  logic            inm,
    output logic [PC_W-1:0] mem_addr,
    input  logic [15:0]     mem_data,
    output logic [4:0]      opcode,
    output logic            zero,
    output logic            carry,
    input  logic [2:0]      dbg_sel,
    output logic [7:0]      dbg_data
);

    logic [PC_W-1:0] pc;
    logic [15:0]     ir;
    logic [7:0]      op_a;
    logic [7:0]      op_b;
    logic [7:0]      rf_b;
    logic [8:0]      res;
    logic [1:0]      unused_ir_bits;

    assign unused_ir_bits = ir[1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= '0;
        end else if (clpc) begin
            pc <= '0;
        end else if (ipc) begin
            pc <= pc + PC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ir <= 16'h0000;
        end else if (wir) begin
            ir <= mem_data;
        end
    end

    data_unit_reg_file u_reg_file (
        .clk      (clk),
        .reset    (reset),
        .we       (wreg),
        .waddr    (f_rd(ir)),
        .wdata    (res[7:0]),
        .raddr_a  (f_ra(ir)),
        .rdata_a  (op_a),
        .raddr_b  (f_rb(ir)),
        .rdata_b  (rf_b),
        .dbg_sel  (dbg_sel),
        .dbg_data (dbg_data)
    );

    assign op_b = inm ? f_imm(ir) : rf_b;

    // Bit 8 is carry-out for ADD and borrow for SUB (9-bit wraparound).
    always_comb begin
        res = 9'h000;
        case (alu_op_t'(op))
            ALU_TRB: res = {1'b0, op_b};
            ALU_ADD: res = {1'b0, op_a} + {1'b0, op_b};
            ALU_SUB: res = {1'b0, op_a} - {1'b0, op_b};
            default: res = 9'h000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            zero  <= 1'b0;
            carry <= 1'b0;
        end else if (wreg) begin
            zero  <= (res[7:0] == 8'h00);
            carry <= res[8];
        end
    end

    assign mem_addr = pc;
    assign opcode   = f_opcode(ir);

endmodule

// File: tb/tb_data_unit.sv
// tb/tb_data_unit.sv - scoreboard bench for data_unit
module tb_data_unit;
    import data_unit_pkg::*;

    logic        clk;
    logic        reset;
    logic [1:0]  op;
    logic        ipc;
    logic        clpc;
    logic        wir;
    logic        wreg;
    logic        inm;
    logic [7:0]  mem_addr;
    logic [15:0] mem_data;
    logic [4:0]  opcode;
    logic        zero;
    logic        carry;
    logic [2:0]  dbg_sel;
    logic [7:0]  dbg_data;

    data_unit #(.PC_W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .op       (op),
        .ipc      (ipc),
        .clpc     (clpc),
        .wir      (wir),
        .wreg     (wreg),
        .inm      (inm),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .opcode   (opcode),
        .zero     (zero),
        .carry    (carry),
        .dbg_sel  (dbg_sel),
        .dbg_data (dbg_data)
    );

    initial begin
        clk = 1'b0;
        forever #20 clk = ~clk;
    end

    typedef struct packed {
        logic [7:0]      pc;
        logic [4:0]      opc;
        logic            z;
        logic            c;
        logic [7:0][7:0] regs;
    } exp_t;

    exp_t        sb [$];
    int          n_checks = 0;
    int          n_errors = 0;

    logic [7:0]  m_pc;
    logic [15:0] m_ir;
    logic [7:0]  m_r [8];
    logic        m_z;
    logic        m_c;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic read_reg(input logic [2:0] idx, output logic [7:0] val);
        dbg_sel = idx;
        #1;
        val = dbg_data;
    endtask

    task automatic cycle(input logic rst, input logic wir_i, input logic ipc_i, input logic clpc_i,
                         input logic wreg_i, input logic inm_i, input logic [1:0] op_i,
                         input logic [15:0] md);
        logic [7:0] a, b, rv;
        logic [8:0] res;
        exp_t       e;
        reset = rst; wir = wir_i; ipc = ipc_i; clpc = clpc_i;
        wreg = wreg_i; inm = inm_i; op = op_i; mem_data = md;

        a = m_r[m_ir[7:5]];
        b = inm_i ? m_ir[7:0] : m_r[m_ir[4:2]];
        case (op_i)
            2'd0:    res = {1'b0, b};
            2'd1:    res = {1'b0, a} + {1'b0, b};
            2'd2:    res = {1'b0, a} - {1'b0, b};
            default: res = 9'h000;
        endcase
        if (rst) begin
            m_pc = 8'h00; m_ir = 16'h0000; m_z = 1'b0; m_c = 1'b0;
            for (int i = 0; i < 8; i++) m_r[i] = 8'h00;
        end else begin
            if (wreg_i) begin
                m_r[m_ir[10:8]] = res[7:0];
                m_z = (res[7:0] == 8'h00);
                m_c = res[8];
            end
            if (wir_i) m_ir = md;
            if (clpc_i) m_pc = 8'h00;
            else if (ipc_i) m_pc = m_pc + 8'h01;
        end
        e.pc = m_pc; e.opc = m_ir[15:11]; e.z = m_z; e.c = m_c;
        for (int i = 0; i < 8; i++) e.regs[i] = m_r[i];
        sb.push_back(e);

        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("mem_addr", {8'h00, mem_addr}, {8'h00, e.pc});
        chk("opcode", {11'h0, opcode}, {11'h0, e.opc});
        chk("zero", {15'h0, zero}, {15'h0, e.z});
        chk("carry", {15'h0, carry}, {15'h0, e.c});
        for (int i = 0; i < 8; i++) begin
            read_reg(3'(i), rv);
            chk($sformatf("r%0d", i), {8'h00, rv}, {8'h00, e.regs[i]});
        end
    endtask

    task automatic fetch(input logic [15:0] w);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, w);
    endtask

    task automatic exec(input logic [1:0] o, input logic im);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, im, o, 16'h0000);
    endtask

    function automatic logic [15:0] ins_r(input opcode_t o, input logic [2:0] rd,
                                          input logic [2:0] ra, input logic [2:0] rb);
        return {o, rd, ra, rb, 2'b00};
    endfunction

    function automatic logic [15:0] ins_i(input opcode_t o, input logic [2:0] rd, input logic [7:0] imm);
        return {o, rd, imm};
    endfunction

    task automatic ldi(input logic [2:0] rd, input logic [7:0] v);
        fetch(ins_i(OPC_LDI, rd, v));
        exec(ALU_TRB, 1'b1);
    endtask

    logic [7:0] rv;

    initial begin
        reset = 1'b0; op = 2'd0; ipc = 1'b0; clpc = 1'b0; wir = 1'b0;
        wreg = 1'b0; inm = 1'b0; mem_data = 16'h0000; dbg_sel = 3'd0;
        m_pc = 8'h00; m_ir = 16'h0000; m_z = 1'b0; m_c = 1'b0;
        for (int i = 0; i < 8; i++) m_r[i] = 8'h00;
        @(negedge clk);

        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000);
        chk("rst_opcode", {11'h0, opcode}, 16'h0000);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000);
        chk("pc_at_5", {8'h00, mem_addr}, 16'h0005);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0000);
        chk("clpc_pc", {8'h00, mem_addr}, 16'h0000);

        ldi(3'd3, 8'h7F);
        read_reg(3'd3, rv);
        chk("ldi_r3", {8'h00, rv}, 16'h007F);
        chk("ldi_pc", {8'h00, mem_addr}, 16'h0001);

        ldi(3'd1, 8'hF0);
        ldi(3'd2, 8'h20);
        fetch(ins_r(OPC_ADD, 3'd4, 3'd1, 3'd2));
        exec(ALU_ADD, 1'b0);
        read_reg(3'd4, rv);
        chk("add_r4", {8'h00, rv}, 16'h0010);
        chk("add_carry", {15'h0, carry}, 16'h0001);
        chk("add_zero", {15'h0, zero}, 16'h0000);
        fetch(ins_r(OPC_SUB, 3'd5, 3'd2, 3'd2));
        exec(ALU_SUB, 1'b0);
        chk("sub_zero", {15'h0, zero}, 16'h0001);
        chk("sub_carry", {15'h0, carry}, 16'h0000);

        ldi(3'd1, 8'h05);
        ldi(3'd2, 8'h07);
        fetch(ins_r(OPC_SUB, 3'd1, 3'd1, 3'd2));
        exec(ALU_SUB, 1'b0);
        read_reg(3'd1, rv);
        chk("borrow_r1", {8'h00, rv}, 16'h00FE);
        chk("borrow_c", {15'h0, carry}, 16'h0001);
        fetch(ins_r(OPC_MOV, 3'd6, 3'd0, 3'd1));
        exec(ALU_TRB, 1'b0);
        read_reg(3'd6, rv);
        chk("mov_r6", {8'h00, rv}, 16'h00FE);
        chk("mov_c", {15'h0, carry}, 16'h0000);

        fetch(ins_r(OPC_ADD, 3'd7, 3'd1, 3'd2));
        exec(ALU_RSV, 1'b0);
        chk("rsv_zero", {15'h0, zero}, 16'h0001);

        fetch(ins_r(OPC_ADD, 3'd0, 3'd2, 3'd2));
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, ALU_ADD, ins_i(OPC_LDI, 3'd5, 8'h99));
        read_reg(3'd0, rv);
        chk("wir_wreg_r0", {8'h00, rv}, 16'h000E);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, ALU_TRB, 16'hFFFF);
        read_reg(3'd5, rv);
        chk("no_wir_r5", {8'h00, rv}, 16'h0099);

        while (m_pc != 8'hFF) cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000);
        chk("pc_wrap", {8'h00, mem_addr}, 16'h0000);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0000);
        chk("clpc_prio", {8'h00, mem_addr}, 16'h0000);

        ldi(3'd3, 8'h11);
        fetch(ins_i(OPC_LDI, 3'd3, 8'h55));
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, ALU_TRB, 16'h0000);
        read_reg(3'd3, rv);
        chk("mid_rst_r3", {8'h00, rv}, 16'h0000);
        chk("mid_rst_opc", {11'h0, opcode}, 16'h0000);

        for (int i = 0; i < 60; i++) begin
            cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 16'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
